// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared default geometry and latency for the memory responder
package mem_responder_pkg;
  localparam int MR_DATA_W       = 64;
  localparam int MR_ADDR_W       = 13;
  localparam int MR_LANES        = MR_DATA_W / 8;
  localparam int MR_LOAD_LATENCY = 1;
endpackage

// File: rtl/mem_read_pipe.sv
// mem_read_pipe: clearable delay line appended after an array read register
module mem_read_pipe #(
  parameter int W      = 64,
  parameter int STAGES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] pipe_q [STAGES];
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
    else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  assign q_o = pipe_q[STAGES-1];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: dual-read, byte-write memory with fixed load latency and a program-loader port
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_W       = MR_DATA_W,
  parameter int ADDR_W       = MR_ADDR_W,
  parameter int LOAD_LATENCY = MR_LOAD_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_to_mem,
  output logic [DATA_W-1:0] ld_data_for_inst,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W/8-1:0] we,
  output logic [DATA_W-1:0] ld_data,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [ADDR_W:0]   prog_words
);
  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PW_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PW_ONE = (ADDR_W + 1)'(1);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] inst_q, data_q, wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic [LANES-1:0]  wr_be;
  logic [ADDR_W:0]   prog_words_q, prog_words_d;
  logic              data_wr, prog_fire;
  assign prog_ready = !rst && (we == '0);
  // Core data writes and loader writes are mutually exclusive, so one write port suffices
  always_comb begin
    data_wr      = |we;
    prog_fire    = prog_valid && prog_ready;
    wr_be        = data_wr ? we : (prog_fire ? '1 : '0);
    wr_addr      = data_wr ? mem_addr : prog_addr;
    wr_data      = data_wr ? st_data : prog_data;
    prog_words_d = (prog_fire && prog_words_q != PW_MAX) ? prog_words_q + PW_ONE : prog_words_q;
  end
  always_ff @(posedge clk)
    if (!rst)
      for (int i = 0; i < LANES; i++)
        if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
  always_ff @(posedge clk) begin
    inst_q       <= rst ? '0 : mem_q[pc_to_mem];
    data_q       <= rst ? '0 : mem_q[mem_addr];
    prog_words_q <= rst ? '0 : prog_words_d;
  end
  assign prog_words = prog_words_q;
  if (LOAD_LATENCY > 1) begin : g_pipe
    mem_read_pipe #(.W(DATA_W), .STAGES(LOAD_LATENCY - 1)) u_inst_pipe (
      .clk(clk), .rst(rst), .d_i(inst_q), .q_o(ld_data_for_inst));
    mem_read_pipe #(.W(DATA_W), .STAGES(LOAD_LATENCY - 1)) u_data_pipe (
      .clk(clk), .rst(rst), .d_i(data_q), .q_o(ld_data));
  end else begin : g_direct
    assign ld_data_for_inst = inst_q;
    assign ld_data          = data_q;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (latency-2 main instance, 2-bit-address loader instance)
module tb_mem_responder;
  localparam int LL = 2;
  typedef struct {
    bit          chk;
    logic [63:0] ei;
    logic [63:0] ed;
    string       tag;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] pc_to_mem = '0, mem_addr = '0, prog_addr = '0;
  logic [63:0] st_data = '0, prog_data = '0, ld_data_for_inst, ld_data;
  logic [7:0]  we = '0;
  logic        prog_valid = 1'b0, prog_ready;
  logic [13:0] prog_words;
  logic        s_rst = 1'b1, s_prog_valid = 1'b0, s_prog_ready;
  logic [1:0]  s_pc = '0, s_mem_addr = '0, s_prog_addr = '0;
  logic [63:0] s_st_data = '0, s_prog_data = '0, s_inst, s_ld;
  logic [7:0]  s_we = '0;
  logic [2:0]  s_prog_words;
  logic [63:0] model [int];
  exp_t        sbq [$];
  int          pw_exp = 0;
  int          ncmp = 0, nerr = 0;
  always #5 clk = ~clk;
  mem_responder #(.DATA_W(64), .ADDR_W(13), .LOAD_LATENCY(LL)) dut (
    .clk(clk), .rst(rst), .pc_to_mem(pc_to_mem), .ld_data_for_inst(ld_data_for_inst),
    .mem_addr(mem_addr), .st_data(st_data), .we(we), .ld_data(ld_data),
    .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_words(prog_words));
  mem_responder #(.DATA_W(64), .ADDR_W(2), .LOAD_LATENCY(1)) dut_s (
    .clk(clk), .rst(s_rst), .pc_to_mem(s_pc), .ld_data_for_inst(s_inst),
    .mem_addr(s_mem_addr), .st_data(s_st_data), .we(s_we), .ld_data(s_ld),
    .prog_valid(s_prog_valid), .prog_ready(s_prog_ready), .prog_addr(s_prog_addr),
    .prog_data(s_prog_data), .prog_words(s_prog_words));
  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] rd(input int a);
    return model.exists(a) ? model[a] : 'x;
  endfunction
  function automatic logic [63:0] pre_val(input int a);
    return a == 5 ? 64'h1122334455667788 : a == 3 ? 64'h1111111122222222 :
           a == 7 ? 64'h0 : {32'hC0DE0000 + 32'(a), 32'(a) * 32'h01010101};
  endfunction
  task automatic step(input logic r, input logic [12:0] pc, input logic [12:0] ma,
                      input logic [63:0] sd, input logic [7:0] w, input logic pv,
                      input logic [12:0] pa, input logic [63:0] pd, input bit chk,
                      input string tag);
    exp_t e;
    logic [63:0] t;
    @(negedge clk);
    rst = r; pc_to_mem = pc; mem_addr = ma; st_data = sd; we = w;
    prog_valid = pv; prog_addr = pa; prog_data = pd;
    #1 cmp({tag, "/prog_ready"}, 64'(prog_ready), 64'(!r && w == 8'h0));
    if (r) foreach (sbq[i]) begin sbq[i].ei = '0; sbq[i].ed = '0; sbq[i].chk = 1'b1; end
    e.chk = chk; e.tag = tag;
    e.ei = r ? 64'h0 : rd(int'(pc));
    e.ed = r ? 64'h0 : rd(int'(ma));
    sbq.push_back(e);
    if (r) pw_exp = 0;
    else if (w != 8'h0) begin
      t = rd(int'(ma));
      for (int b = 0; b < 8; b++) if (w[b]) t[8*b +: 8] = sd[8*b +: 8];
      model[int'(ma)] = t;
    end else if (pv) begin
      model[int'(pa)] = pd;
      if (pw_exp < 8192) pw_exp++;
    end
    @(posedge clk);
    #1;
    if (sbq.size() == LL) begin
      e = sbq.pop_front();
      if (e.chk) begin
        cmp({e.tag, "/inst"}, ld_data_for_inst, e.ei);
        cmp({e.tag, "/data"}, ld_data, e.ed);
      end
    end
    cmp({tag, "/prog_words"}, 64'(prog_words), 64'(pw_exp));
  endtask
  task automatic idle(input logic [12:0] pc, input logic [12:0] ma, input string tag);
    step(1'b0, pc, ma, '0, '0, 1'b0, '0, '0, 1'b1, tag);
  endtask
  initial begin
    step(1'b1, '0, '0, '0, '0, 1'b0, '0, '0, 1'b1, "rst0");
    cmp("rst0/clear_inst", ld_data_for_inst, 64'h0);
    for (int a = 0; a < 16; a++)
      step(1'b0, '0, '0, '0, '0, 1'b1, 13'(a), pre_val(a), 1'b0, "preload");
    step(1'b1, 13'd5, 13'd5, '0, '0, 1'b0, '0, '0, 1'b1, "rst1");
    cmp("rst1/clear_inst", ld_data_for_inst, 64'h0);
    cmp("rst1/clear_data", ld_data, 64'h0);
    idle(13'd5, 13'd5, "fetch5");
    idle(13'd5, 13'd5, "fetch5b");
    step(1'b0, 13'd5, 13'd3, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 1'b0, '0, '0, 1'b1, "bytewr");
    idle(13'd3, 13'd3, "bytewr_rd");
    cmp("bytewr/model", rd(3), 64'h11111111BBBBBBBB);
    step(1'b0, 13'd7, 13'd7, 64'hDEAD, 8'hFF, 1'b0, '0, '0, 1'b1, "rdw_old");
    idle(13'd7, 13'd7, "rdw_new");
    step(1'b0, 13'd7, 13'd12, 64'h5555, 8'hFF, 1'b1, 13'd0, 64'h42, 1'b1, "ldr_blocked");
    step(1'b0, 13'd12, 13'd12, '0, '0, 1'b1, 13'd0, 64'h42, 1'b1, "ldr_accept");
    idle(13'd0, 13'd0, "ldr_rd");
    idle(13'd0, 13'd5, "ldr_rd2");
    step(1'b1, 13'd9, 13'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 13'd9, 64'h1, 1'b1, "rst_mid");
    cmp("rst_mid/clear_inst", ld_data_for_inst, 64'h0);
    cmp("rst_mid/clear_data", ld_data, 64'h0);
    idle(13'd9, 13'd9, "post_rst");
    idle(13'd9, 13'd9, "post_rst2");
    for (int k = 0; k < 40; k++)
      step(1'b0, 13'($urandom_range(0, 15)), 13'($urandom_range(0, 15)),
           {$urandom, $urandom}, ($urandom_range(0, 1) == 0) ? 8'h0 : 8'($urandom),
           1'($urandom), 13'($urandom_range(0, 15)), {$urandom, $urandom}, 1'b1, "rand");
    idle('0, '0, "drain");
    idle('0, '0, "drain2");
    @(negedge clk);
    s_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_prog_valid = 1'b1; s_prog_addr = 2'(k); s_prog_data = 64'(k + 100);
      @(posedge clk);
      #1 cmp($sformatf("sat/prog_words%0d", k), 64'(s_prog_words), 64'(k < 4 ? k + 1 : 4));
      @(negedge clk);
    end
    s_prog_valid = 1'b0; s_pc = 2'd0; s_mem_addr = 2'd3;
    @(posedge clk);
    #1 cmp("sat/inst_addr0", s_inst, 64'd104);
    cmp("sat/data_addr3", s_ld, 64'd103);
    cmp("sat/prog_words_hold", 64'(s_prog_words), 64'd4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
